// File: rtl/ycbcr_thr_pkg.sv
// ycbcr_thr_pkg
// Shared constants for the streaming YCbCr skin thresholder: configuration
// register addresses, the 8-bit default skin window, and a helper that
// scales those defaults to the configured component width.
package ycbcr_thr_pkg;

  localparam logic [1:0] THR_TA = 2'd0;  // Cb lower bound
  localparam logic [1:0] THR_TB = 2'd1;  // Cb upper bound
  localparam logic [1:0] THR_TC = 2'd2;  // Cr lower bound
  localparam logic [1:0] THR_TD = 2'd3;  // Cr upper bound

  localparam logic [7:0] DEF_TA = 8'd77;
  localparam logic [7:0] DEF_TB = 8'd127;
  localparam logic [7:0] DEF_TC = 8'd133;
  localparam logic [7:0] DEF_TD = 8'd173;

  // Defaults are tuned for 8-bit video; wider paths keep the same fraction
  // of full scale by shifting left.
  function automatic logic [31:0] scale_thr(input logic [7:0] base, input int data_w);
    return 32'(base) << (data_w - 8);
  endfunction

endpackage

// File: rtl/ycbcr_range_cmp.sv
// ycbcr_range_cmp
// Unsigned window compare of one chroma component.
// Ports:
//   x        component value
//   lo, hi   window bounds
//   in_range 1 when x lies inside the window (strict or inclusive)
// A crossed window (lo > hi, or lo == hi when strict) can never match.
module ycbcr_range_cmp #(
  parameter int DATA_W    = 8,
  parameter int INCLUSIVE = 0
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              in_range
);

  generate
    if (INCLUSIVE != 0) begin : g_incl
      assign in_range = (x >= lo) && (x <= hi);
    end else begin : g_strict
      assign in_range = (x > lo) && (x < hi);
    end
  endgenerate

endmodule

// File: rtl/ycbcr_threshold_stream.sv
// ycbcr_threshold_stream
// Two-stage ready/valid skin classifier with frame-synchronous thresholds
// and a per-frame skin-pixel counter.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we, cfg_addr, cfg_data    pending threshold write (0=Ta 1=Tb 2=Tc 3=Td)
//   in_valid/in_ready             input handshake
//   in_y, in_cb, in_cr            pixel components (Y is not used)
//   in_sof, in_eof                frame markers
//   out_valid/out_ready           output handshake
//   out_mask                      all-ones = skin, all-zeros = not skin
//   out_sof, out_eof              frame markers aligned with out_mask
//   skin_count, count_valid       last completed frame's count, update pulse
module ycbcr_threshold_stream
  import ycbcr_thr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 20,
  parameter int INCLUSIVE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_cb,
  input  logic [DATA_W-1:0] in_cr,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mask,
  output logic              out_sof,
  output logic              out_eof,
  output logic [CNT_W-1:0]  skin_count,
  output logic              count_valid
);

  localparam logic [DATA_W-1:0] RST_TA = DATA_W'(scale_thr(DEF_TA, DATA_W));
  localparam logic [DATA_W-1:0] RST_TB = DATA_W'(scale_thr(DEF_TB, DATA_W));
  localparam logic [DATA_W-1:0] RST_TC = DATA_W'(scale_thr(DEF_TC, DATA_W));
  localparam logic [DATA_W-1:0] RST_TD = DATA_W'(scale_thr(DEF_TD, DATA_W));

  logic [DATA_W-1:0] pend [4];
  logic [DATA_W-1:0] act  [4];

  logic en, accept, load;
  logic [DATA_W-1:0] lo_cb, hi_cb, lo_cr, hi_cr;
  logic cb_ok, cr_ok;

  logic s1_valid, s1_cb_ok, s1_cr_ok, s1_sof, s1_eof;

  logic [CNT_W-1:0] run_cnt, base_cnt, next_cnt;
  logic             out_fire;

  // Y travels with the pixel upstream but plays no part in classification.
  logic unused_y;
  assign unused_y = ^in_y;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign load     = accept && in_sof;

  // Pending writes land on any cycle; the active set only changes on an
  // accepted SOF, so a frame is always classified with one threshold set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend[THR_TA] <= RST_TA;
      pend[THR_TB] <= RST_TB;
      pend[THR_TC] <= RST_TC;
      pend[THR_TD] <= RST_TD;
      act[THR_TA]  <= RST_TA;
      act[THR_TB]  <= RST_TB;
      act[THR_TC]  <= RST_TC;
      act[THR_TD]  <= RST_TD;
    end else begin
      if (cfg_we) pend[cfg_addr] <= cfg_data;
      if (load) begin
        act[THR_TA] <= pend[THR_TA];
        act[THR_TB] <= pend[THR_TB];
        act[THR_TC] <= pend[THR_TC];
        act[THR_TD] <= pend[THR_TD];
      end
    end
  end

  // The SOF pixel itself already uses the incoming set.
  assign lo_cb = load ? pend[THR_TA] : act[THR_TA];
  assign hi_cb = load ? pend[THR_TB] : act[THR_TB];
  assign lo_cr = load ? pend[THR_TC] : act[THR_TC];
  assign hi_cr = load ? pend[THR_TD] : act[THR_TD];

  ycbcr_range_cmp #(.DATA_W(DATA_W), .INCLUSIVE(INCLUSIVE)) u_cmp_cb (
    .x(in_cb), .lo(lo_cb), .hi(hi_cb), .in_range(cb_ok)
  );

  ycbcr_range_cmp #(.DATA_W(DATA_W), .INCLUSIVE(INCLUSIVE)) u_cmp_cr (
    .x(in_cr), .lo(lo_cr), .hi(hi_cr), .in_range(cr_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cb_ok <= 1'b0;
      s1_cr_ok <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_cb_ok <= cb_ok;
      s1_cr_ok <= cr_ok;
      s1_sof   <= in_valid && in_sof;
      s1_eof   <= in_valid && in_eof;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_mask  <= (s1_valid && s1_cb_ok && s1_cr_ok) ? '1 : '0;
      out_sof   <= s1_sof;
      out_eof   <= s1_eof;
    end
  end

  assign out_fire = out_valid && out_ready;

  // SOF restarts the count before this pixel is added, so a single-beat
  // SOF+EOF frame publishes exactly its own mask bit.
  always_comb begin
    base_cnt = out_sof ? '0 : run_cnt;
    next_cnt = base_cnt;
    if (out_mask[0] && (base_cnt != '1)) next_cnt = base_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      skin_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (out_fire) begin
        if (out_eof) begin
          skin_count  <= next_cnt;
          count_valid <= 1'b1;
          run_cnt     <= '0;
        end else begin
          run_cnt <= next_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_threshold_stream.sv
// Scoreboarded bench: two instances share one stimulus stream.
//   d0: DATA_W=8, CNT_W=20, strict compares
//   d1: DATA_W=8, CNT_W=3,  inclusive compares (also exercises saturation)
// Each directed pixel carries hand-computed masks for both instances; each
// EOF pixel carries hand-computed frame counts.
module tb_ycbcr_threshold_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       in_valid;
  logic [7:0] in_y, in_cb, in_cr;
  logic       in_sof, in_eof;
  logic       out_ready;

  logic       ir0, ov0, os0, oe0, cv0;
  logic [7:0] om0;
  logic [19:0] sc0;
  logic       ir1, ov1, os1, oe1, cv1;
  logic [7:0] om1;
  logic [2:0] sc1;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [7:0] mq0[$], mq1[$];
  int         cq0[$], cq1[$];

  bit bp_en = 0;
  int bp_i  = 0;
  bit lat_arm = 0, lat_wait = 0;
  int acc_cyc = 0;

  ycbcr_threshold_stream #(.DATA_W(8), .CNT_W(20), .INCLUSIVE(0)) d0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(ir0), .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(ov0), .out_ready(out_ready),
    .out_mask(om0), .out_sof(os0), .out_eof(oe0), .skin_count(sc0), .count_valid(cv0)
  );

  ycbcr_threshold_stream #(.DATA_W(8), .CNT_W(3), .INCLUSIVE(1)) d1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(ir1), .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(ov1), .out_ready(out_ready),
    .out_mask(om1), .out_sof(os1), .out_eof(oe1), .skin_count(sc1), .count_valid(cv1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure pattern 1,0,0,1 repeating while enabled.
  always @(negedge clk) begin
    if (bp_en) begin
      out_ready = ((bp_i % 4) == 0) || ((bp_i % 4) == 3);
      bp_i++;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: samples just before the edge on which a handshake would occur.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("in_ready0", int'(ir0), int'(out_ready || !ov0));
      check("in_ready1", int'(ir1), int'(out_ready || !ov1));
      if (ov0 && out_ready) begin
        if (mq0.size() == 0) check("extra_out0", 1, 0);
        else begin
          check("mask0", int'(om0), int'(mq0.pop_front()));
          if (lat_wait) begin
            check("latency", cyc - acc_cyc, 2);
            lat_wait = 0;
          end
        end
      end
      if (ov1 && out_ready) begin
        if (mq1.size() == 0) check("extra_out1", 1, 0);
        else check("mask1", int'(om1), int'(mq1.pop_front()));
      end
      if (cv0) begin
        if (cq0.size() == 0) check("extra_count0", 1, 0);
        else check("count0", int'(sc0), cq0.pop_front());
      end
      if (cv1) begin
        if (cq1.size() == 0) check("extra_count1", 1, 0);
        else check("count1", int'(sc1), cq1.pop_front());
      end
    end
  end

  task automatic send(input int cb, input int cr, input bit sof, input bit eof,
                      input logic [7:0] m0, input logic [7:0] m1,
                      input int c0 = 0, input int c1 = 0,
                      input bit we = 0, input int addr = 0, input int data = 0);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_cb    = 8'(cb);
    in_cr    = 8'(cr);
    in_sof   = sof;
    in_eof   = eof;
    cfg_we   = we;
    cfg_addr = 2'(addr);
    cfg_data = 8'(data);
    mq0.push_back(m0);
    mq1.push_back(m1);
    if (eof) begin
      cq0.push_back(c0);
      cq1.push_back(c1);
    end
    n = 0;
    #1;
    while (!ir0 && n < 100) begin
      @(posedge clk);
      #1 cfg_we = 1'b0;
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", 1, 0);
    if (lat_arm) begin
      acc_cyc  = cyc;
      lat_arm  = 0;
      lat_wait = 1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 2'(addr);
    cfg_data = 8'(data);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    in_valid = 0; in_y = 8'h80; in_cb = 0; in_cr = 0; in_sof = 0; in_eof = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(ov0), 0);
    check("rst_count_valid", int'(cv0), 0);
    check("rst_skin_count", int'(sc0), 0);
    check("rst_out_mask", int'(om0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Default window, strict vs inclusive boundaries.
    lat_arm = 1;
    send(100, 150, 1, 0, 8'hFF, 8'hFF);
    send( 77, 150, 0, 0, 8'h00, 8'hFF);
    send(127, 150, 0, 0, 8'h00, 8'hFF);
    send(100, 173, 0, 0, 8'h00, 8'hFF);
    send(100, 174, 0, 1, 8'h00, 8'h00, 1, 4);

    // Backpressure with mixed boundary pixels.
    bp_en = 1;
    send(100, 150, 1, 0, 8'hFF, 8'hFF);
    send( 77, 150, 0, 0, 8'h00, 8'hFF);
    send( 90, 140, 0, 0, 8'hFF, 8'hFF);
    send(127, 134, 0, 0, 8'h00, 8'hFF);
    send(126, 172, 0, 0, 8'hFF, 8'hFF);
    send( 78, 133, 0, 0, 8'h00, 8'hFF);
    send(100, 173, 0, 0, 8'h00, 8'hFF);
    send( 50, 150, 0, 1, 8'h00, 8'h00, 3, 7);
    bp_en = 0;

    // Shadowing: mid-frame write must not affect the current frame.
    send(100, 150, 1, 0, 8'hFF, 8'hFF);
    send(100, 150, 0, 0, 8'hFF, 8'hFF);
    cfg_write(0, 120);
    send(100, 150, 0, 0, 8'hFF, 8'hFF);
    send(100, 150, 0, 1, 8'hFF, 8'hFF, 4, 4);
    send(110, 150, 1, 0, 8'h00, 8'h00);
    send(125, 150, 0, 0, 8'hFF, 8'hFF);
    send(110, 150, 0, 1, 8'h00, 8'h00, 1, 1);
    // Write coinciding with SOF waits for the following frame.
    send(110, 150, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 77);
    send(110, 150, 0, 1, 8'h00, 8'h00, 0, 0);
    send(110, 150, 1, 1, 8'hFF, 8'hFF, 1, 1);
    send( 50, 150, 1, 1, 8'h00, 8'h00, 0, 0);

    // 16-pixel frame with 5 skin pixels.
    for (int i = 0; i < 16; i++) begin
      bit skin;
      skin = (i == 0) || (i == 3) || (i == 7) || (i == 8) || (i == 15);
      send(skin ? 100 : 50, 150, i == 0, i == 15,
           skin ? 8'hFF : 8'h00, skin ? 8'hFF : 8'h00, 5, 5);
    end

    // Ten skin pixels: d1's 3-bit counter saturates at 7.
    for (int i = 0; i < 10; i++)
      send(100, 150, i == 0, i == 9, 8'hFF, 8'hFF, 10, 7);

    // lo == hi: strict never matches, inclusive matches exactly.
    cfg_write(0, 100);
    cfg_write(1, 100);
    send(100, 150, 1, 1, 8'h00, 8'hFF, 0, 1);
    // Crossed window.
    cfg_write(0, 130);
    cfg_write(1, 120);
    send(125, 150, 1, 1, 8'h00, 8'h00, 0, 0);

    // Reset mid-frame: partial frame with a non-default pending Ta.
    cfg_write(0, 120);
    send(100, 150, 1, 0, 8'h00, 8'h00);
    send(100, 150, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    mq0.delete(); mq1.delete(); cq0.delete(); cq1.delete();
    @(posedge clk);
    #1;
    check("rstmid_out_valid0", int'(ov0), 0);
    check("rstmid_out_valid1", int'(ov1), 0);
    check("rstmid_count_valid", int'(cv0), 0);
    check("rstmid_skin_count", int'(sc0), 0);
    @(negedge clk);
    rst = 1'b0;
    // Defaults restored: Cb=100 passes Ta=77 again; Cr edges near Tc/Td.
    send(100, 150, 1, 1, 8'hFF, 8'hFF, 1, 1);
    send(126, 172, 1, 0, 8'hFF, 8'hFF);
    send(100, 133, 0, 1, 8'h00, 8'hFF, 1, 2);

    for (int i = 0; i < 200; i++) begin
      if (mq0.size() == 0 && mq1.size() == 0 && cq0.size() == 0 && cq1.size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    check("drained", mq0.size() + mq1.size() + cq0.size() + cq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
